// File: rtl/sys_bus_arb_pkg.sv
// Shared types and defaults for the multi-master system bus controller.
// The optional data-phase timeout is enabled with the SYS_BUS_TIMEOUT_EN macro.
package sys_bus_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ADDR = 2'd1,
      ST_DATA = 2'd2,
      ST_DONE = 2'd3
   } bus_state_e;

   localparam int DEF_NUM_MASTERS = 4;
   localparam int DEF_ADDR_W      = 8;
   localparam int DEF_DATA_W      = 32;
   localparam int DEF_TIMEOUT_CYC = 16;

   // Width of a master index; never narrower than one bit.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/sys_bus_arb_if.sv
// Master-side request/grant signals and slave-side address/data phase signals.
// ctrl is the controller's view; master and slave are the requester and device views.
interface sys_bus_arb_if #(
   parameter int NUM_MASTERS = 4,
   parameter int ADDR_W      = 8,
   parameter int DATA_W      = 32
) ();

   logic [NUM_MASTERS-1:0]        m_req;
   logic [NUM_MASTERS-1:0]        m_we;
   logic [NUM_MASTERS*ADDR_W-1:0] m_addr;
   logic [NUM_MASTERS*DATA_W-1:0] m_wdata;
   logic [NUM_MASTERS-1:0]        m_gnt;
   logic [NUM_MASTERS-1:0]        m_done;
   logic [DATA_W-1:0]             m_rdata;
   logic                          m_err;

   logic                          s_ale;
   logic [ADDR_W-1:0]             s_addr;
   logic                          s_rd_en;
   logic                          s_wr_en;
   logic [DATA_W-1:0]             s_wdata;
   logic [DATA_W-1:0]             s_rdata;
   logic                          s_ready;

   modport ctrl (
      input  m_req, m_we, m_addr, m_wdata, s_rdata, s_ready,
      output m_gnt, m_done, m_rdata, m_err,
      output s_ale, s_addr, s_rd_en, s_wr_en, s_wdata
   );

   modport master (
      output m_req, m_we, m_addr, m_wdata,
      input  m_gnt, m_done, m_rdata, m_err
   );

   modport slave (
      input  s_ale, s_addr, s_rd_en, s_wr_en, s_wdata,
      output s_rdata, s_ready
   );

endinterface

// File: rtl/sys_bus_arb_rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping to 0.
module rr_arbiter
   import sys_bus_pkg::*;
#(
   parameter int NUM_MASTERS = DEF_NUM_MASTERS,
   parameter int IDX_W       = idx_w(NUM_MASTERS)
) (
   input  logic [NUM_MASTERS-1:0] req,
   input  logic [IDX_W-1:0]       ptr,
   output logic [NUM_MASTERS-1:0] gnt,
   output logic [IDX_W-1:0]       idx,
   output logic                   valid
);

   localparam logic [IDX_W:0] NM = (IDX_W+1)'(NUM_MASTERS);

   logic [IDX_W:0] cand;

   // Scan from the farthest offset down so the nearest requester is written last.
   always_comb begin
      gnt   = '0;
      idx   = '0;
      valid = 1'b0;
      cand  = '0;
      for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
         cand = {1'b0, ptr} + (IDX_W+1)'(i);
         if (cand >= NM)
            cand = cand - NM;
         if (req[cand[IDX_W-1:0]]) begin
            gnt                   = '0;
            gnt[cand[IDX_W-1:0]]  = 1'b1;
            idx                   = cand[IDX_W-1:0];
            valid                 = 1'b1;
         end
      end
   end

endmodule

// File: rtl/sys_bus_arb.sv
// Round-robin multi-master bus controller running multiplexed address/data bus cycles.
// Define SYS_BUS_TIMEOUT_EN to abort data phases lasting TIMEOUT_CYC cycles with m_err.
module sys_bus_arb
   import sys_bus_pkg::*;
#(
   parameter int NUM_MASTERS = DEF_NUM_MASTERS,
   parameter int ADDR_W      = DEF_ADDR_W,
   parameter int DATA_W      = DEF_DATA_W,
   parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
   input  logic          clk,
   input  logic          rst,
   sys_bus_arb_if.ctrl   bus
);

   localparam int IDX_W = idx_w(NUM_MASTERS);

   localparam logic [1:0] IDLE = ST_IDLE;
   localparam logic [1:0] ADDR = ST_ADDR;
   localparam logic [1:0] DATA = ST_DATA;
   localparam logic [1:0] DONE = ST_DONE;

   if (NUM_MASTERS < 2) begin : g_bad_masters
      $error("sys_bus_arb: NUM_MASTERS must be at least 2");
   end
   if (TIMEOUT_CYC < 1) begin : g_bad_timeout
      $error("sys_bus_arb: TIMEOUT_CYC must be at least 1");
   end

   logic [1:0]             state;
   logic [IDX_W-1:0]       ptr;
   logic [IDX_W-1:0]       win_idx;
   logic                   we_q;
   logic [NUM_MASTERS-1:0] arb_gnt;
   logic [IDX_W-1:0]       arb_idx;
   logic                   arb_vld;

`ifdef SYS_BUS_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
   logic [CNT_W-1:0] to_cnt;
`else
   assign bus.m_err = 1'b0;
`endif

   rr_arbiter #(.NUM_MASTERS(NUM_MASTERS), .IDX_W(IDX_W)) u_arb (
      .req   (bus.m_req),
      .ptr   (ptr),
      .gnt   (arb_gnt),
      .idx   (arb_idx),
      .valid (arb_vld)
   );

   // A nonzero m_gnt while IDLE marks the arbitration cycle; the next edge opens ADDR.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state       <= IDLE;
         ptr         <= '0;
         win_idx     <= '0;
         we_q        <= 1'b0;
         bus.m_gnt   <= '0;
         bus.m_done  <= '0;
         bus.m_rdata <= '0;
         bus.s_ale   <= 1'b0;
         bus.s_addr  <= '0;
         bus.s_rd_en <= 1'b0;
         bus.s_wr_en <= 1'b0;
         bus.s_wdata <= '0;
`ifdef SYS_BUS_TIMEOUT_EN
         bus.m_err   <= 1'b0;
         to_cnt      <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (|bus.m_gnt) begin
                  state     <= ADDR;
                  bus.s_ale <= 1'b1;
               end else if (arb_vld) begin
                  bus.m_gnt   <= arb_gnt;
                  win_idx     <= arb_idx;
                  we_q        <= bus.m_we[arb_idx];
                  bus.s_addr  <= bus.m_addr[arb_idx*ADDR_W +: ADDR_W];
                  bus.s_wdata <= bus.m_wdata[arb_idx*DATA_W +: DATA_W];
               end
            end
            ADDR: begin
               state       <= DATA;
               bus.s_ale   <= 1'b0;
               bus.s_rd_en <= !we_q;
               bus.s_wr_en <= we_q;
            end
            DATA: begin
               if (bus.s_ready) begin
                  state       <= DONE;
                  bus.s_rd_en <= 1'b0;
                  bus.s_wr_en <= 1'b0;
                  bus.m_done  <= bus.m_gnt;
                  bus.m_rdata <= we_q ? '0 : bus.s_rdata;
`ifdef SYS_BUS_TIMEOUT_EN
               end else if (to_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
                  state       <= DONE;
                  bus.s_rd_en <= 1'b0;
                  bus.s_wr_en <= 1'b0;
                  bus.m_done  <= bus.m_gnt;
                  bus.m_rdata <= '0;
                  bus.m_err   <= 1'b1;
               end else begin
                  to_cnt <= to_cnt + 1'b1;
`endif
               end
            end
            DONE: begin
               state       <= IDLE;
               bus.m_done  <= '0;
               bus.m_rdata <= '0;
               bus.m_gnt   <= '0;
               bus.s_addr  <= '0;
               bus.s_wdata <= '0;
               ptr         <= (win_idx == IDX_W'(NUM_MASTERS - 1)) ? '0 : win_idx + 1'b1;
`ifdef SYS_BUS_TIMEOUT_EN
               bus.m_err   <= 1'b0;
               to_cnt      <= '0;
`endif
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sys_bus_arb.sv
// Directed bench for sys_bus_arb; timeout checks follow SYS_BUS_TIMEOUT_EN.
module tb_sys_bus_arb;

   localparam int NM = 4;
   localparam int AW = 8;
   localparam int DW = 32;

   logic clk = 1'b0;
   logic rst;
   int   n_chk  = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   sys_bus_arb_if #(.NUM_MASTERS(NM), .ADDR_W(AW), .DATA_W(DW)) bus ();

   sys_bus_arb #(.NUM_MASTERS(NM), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(16)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_master(input int m, input logic we, input logic [7:0] addr, input logic [31:0] wd);
      bus.m_we[m]             = we;
      bus.m_addr[m*AW +: AW]  = addr;
      bus.m_wdata[m*DW +: DW] = wd;
   endtask

   // Starts in IDLE with requests already driven; returns in IDLE after the DONE cycle.
   task automatic bus_cyc(input string tag, input logic [3:0] gnt_e, input logic we_e,
                          input logic [7:0] addr_e, input logic [31:0] wd_e, input int waits,
                          input logic [31:0] srd, input logic [31:0] rd_e, input logic drop_req);
      tick();
      chk({tag, ".gnt"}, bus.m_gnt, gnt_e);
      chk({tag, ".ale_pre"}, bus.s_ale, 1'b0);
      tick();
      chk({tag, ".ale"}, bus.s_ale, 1'b1);
      chk({tag, ".addr"}, bus.s_addr, addr_e);
      chk({tag, ".gnt_addr"}, bus.m_gnt, gnt_e);
      if (drop_req) bus.m_req = '0;
      tick();
      chk({tag, ".ale_off"}, bus.s_ale, 1'b0);
      chk({tag, ".wr_en"}, bus.s_wr_en, we_e);
      chk({tag, ".rd_en"}, bus.s_rd_en, !we_e);
      if (we_e) chk({tag, ".wdata"}, bus.s_wdata, wd_e);
      for (int w = 0; w < waits; w++) begin
         bus.s_ready = 1'b0;
         tick();
         chk({tag, ".wait_done"}, bus.m_done, 4'b0000);
         chk({tag, ".wait_strobe"}, bus.s_wr_en | bus.s_rd_en, 1'b1);
      end
      bus.s_ready = 1'b1;
      bus.s_rdata = srd;
      tick();
      chk({tag, ".done"}, bus.m_done, gnt_e);
      chk({tag, ".rdata"}, bus.m_rdata, rd_e);
      chk({tag, ".err"}, bus.m_err, 1'b0);
      chk({tag, ".strobe_off"}, bus.s_wr_en | bus.s_rd_en, 1'b0);
      bus.s_ready = 1'b0;
      tick();
      chk({tag, ".done_off"}, bus.m_done, 4'b0000);
      chk({tag, ".gnt_off"}, bus.m_gnt, 4'b0000);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, ".gnt"}, bus.m_gnt, 0);
      chk({tag, ".done"}, bus.m_done, 0);
      chk({tag, ".rdata"}, bus.m_rdata, 0);
      chk({tag, ".err"}, bus.m_err, 0);
      chk({tag, ".ale"}, bus.s_ale, 0);
      chk({tag, ".saddr"}, bus.s_addr, 0);
      chk({tag, ".rd_en"}, bus.s_rd_en, 0);
      chk({tag, ".wr_en"}, bus.s_wr_en, 0);
      chk({tag, ".swdata"}, bus.s_wdata, 0);
   endtask

   // Strobe exclusivity and grant one-hotness hold on every cycle out of reset.
   always @(negedge clk) begin
      if (rst === 1'b1) begin
         chk("strobe_excl", bus.s_rd_en & bus.s_wr_en, 1'b0);
         chk("gnt_onehot0", $onehot0(bus.m_gnt), 1'b1);
      end
   end

   initial begin
      rst          = 1'b0;
      bus.m_req    = '0;
      bus.m_we     = '0;
      bus.m_addr   = '0;
      bus.m_wdata  = '0;
      bus.s_rdata  = '0;
      bus.s_ready  = 1'b0;
      tick();
      tick();
      chk_all_zero("reset");
      rst = 1'b1;

      // All four requesting from pointer 0, then masters 1 and 3 from pointer 1.
      for (int i = 0; i < NM; i++) set_master(i, 1'b0, 8'h40 + 8'(i), 32'h0);
      bus.m_req = 4'b1111;
      bus_cyc("rr0", 4'b0001, 1'b0, 8'h40, 32'h0, 0, 32'h1000_0000, 32'h1000_0000, 1'b0);
      bus_cyc("rr1", 4'b0010, 1'b0, 8'h41, 32'h0, 0, 32'h1000_0001, 32'h1000_0001, 1'b0);
      bus_cyc("rr2", 4'b0100, 1'b0, 8'h42, 32'h0, 0, 32'h1000_0002, 32'h1000_0002, 1'b0);
      bus_cyc("rr3", 4'b1000, 1'b0, 8'h43, 32'h0, 0, 32'h1000_0003, 32'h1000_0003, 1'b0);
      bus_cyc("rr4", 4'b0001, 1'b0, 8'h40, 32'h0, 0, 32'h1000_0004, 32'h1000_0004, 1'b0);
      bus.m_req = 4'b1010;
      bus_cyc("rr5", 4'b0010, 1'b0, 8'h41, 32'h0, 0, 32'h2000_0001, 32'h2000_0001, 1'b0);
      bus_cyc("rr6", 4'b1000, 1'b0, 8'h43, 32'h0, 0, 32'h2000_0003, 32'h2000_0003, 1'b0);
      bus_cyc("rr7", 4'b0010, 1'b0, 8'h41, 32'h0, 0, 32'h2000_0005, 32'h2000_0005, 1'b0);
      bus.m_req = '0;

      // Minimum-latency write with s_ready held high from before the grant.
      set_master(0, 1'b1, 8'h10, 32'hDEAD_BEEF);
      bus.m_req   = 4'b0001;
      bus.s_ready = 1'b1;
      bus_cyc("wr", 4'b0001, 1'b1, 8'h10, 32'hDEAD_BEEF, 0, 32'h1234_5678, 32'h0, 1'b0);
      bus.m_req = '0;

      // Read with three wait cycles.
      set_master(2, 1'b0, 8'h3C, 32'h0);
      bus.m_req = 4'b0100;
      bus_cyc("rd", 4'b0100, 1'b0, 8'h3C, 32'h0, 3, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 1'b0);
      bus.m_req = '0;

      // Request dropped during ADDR; ready arrives on the 16th data cycle.
      set_master(1, 1'b0, 8'h77, 32'h0);
      bus.m_req = 4'b0010;
      bus_cyc("drop", 4'b0010, 1'b0, 8'h77, 32'h0, 15, 32'hC0FF_EE00, 32'hC0FF_EE00, 1'b1);
      bus.m_req = '0;

      // Slave never ready.
      set_master(0, 1'b0, 8'h20, 32'h0);
      bus.m_req   = 4'b0001;
      bus.s_rdata = 32'hFFFF_FFFF;
      tick();
      chk("stall.gnt", bus.m_gnt, 4'b0001);
      bus.m_req = '0;
      tick();
      tick();
      chk("stall.rd_en", bus.s_rd_en, 1'b1);
`ifdef SYS_BUS_TIMEOUT_EN
      for (int w = 0; w < 15; w++) begin
         tick();
         chk("stall.early_done", bus.m_done, 4'b0000);
      end
      tick();
      chk("stall.to_done", bus.m_done, 4'b0001);
      chk("stall.to_err", bus.m_err, 1'b1);
      chk("stall.to_rdata", bus.m_rdata, 32'h0);
      tick();
      chk("stall.err_off", bus.m_err, 1'b0);
`else
      for (int w = 0; w < 20; w++) begin
         tick();
         chk("stall.no_done", bus.m_done, 4'b0000);
      end
      chk("stall.still_rd", bus.s_rd_en, 1'b1);
      bus.s_ready = 1'b1;
      bus.s_rdata = 32'h5555_0001;
      tick();
      chk("stall.done", bus.m_done, 4'b0001);
      chk("stall.rdata", bus.m_rdata, 32'h5555_0001);
      bus.s_ready = 1'b0;
      tick();
`endif
      chk("stall.gnt_off", bus.m_gnt, 4'b0000);

      // Reset in the middle of a data phase.
      set_master(2, 1'b0, 8'h5A, 32'h0);
      set_master(3, 1'b1, 8'h66, 32'h0BAD_F00D);
      bus.m_req = 4'b0100;
      tick();
      chk("mrst.gnt", bus.m_gnt, 4'b0100);
      bus.m_req = '0;
      tick();
      tick();
      tick();
      chk("mrst.in_data", bus.s_rd_en, 1'b1);
      rst = 1'b0;
      tick();
      chk_all_zero("mrst");
      rst       = 1'b1;
      bus.m_req = 4'b1000;
      bus_cyc("post", 4'b1000, 1'b1, 8'h66, 32'h0BAD_F00D, 1, 32'h0, 32'h0, 1'b0);
      // Pointer wrapped from master 3 back to 0.
      bus.m_req = 4'b1001;
      set_master(0, 1'b0, 8'h01, 32'h0);
      bus_cyc("wrap", 4'b0001, 1'b0, 8'h01, 32'h0, 0, 32'h0000_0BB0, 32'h0000_0BB0, 1'b0);
      bus.m_req = '0;
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
